// File: rtl/replay_pkg.sv
// Shared types and constants for the pong replay recorder.
package replay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    HOLD   = 2'd2,
    PLAY   = 2'd3
  } state_e;

  localparam int COORD_W    = 12;
  localparam int NUM_COORDS = 12;
  localparam int SNAP_W     = COORD_W * NUM_COORDS;

  // Bit offsets of each coordinate inside a packed snapshot
  localparam int SQ_A_X1_LSB  = 0 * COORD_W;
  localparam int SQ_A_X2_LSB  = 1 * COORD_W;
  localparam int SQ_A_Y1_LSB  = 2 * COORD_W;
  localparam int SQ_A_Y2_LSB  = 3 * COORD_W;
  localparam int SQ_B_X1_LSB  = 4 * COORD_W;
  localparam int SQ_B_X2_LSB  = 5 * COORD_W;
  localparam int SQ_B_Y1_LSB  = 6 * COORD_W;
  localparam int SQ_B_Y2_LSB  = 7 * COORD_W;
  localparam int SQ_B1_X1_LSB = 8 * COORD_W;
  localparam int SQ_B1_X2_LSB = 9 * COORD_W;
  localparam int SQ_B1_Y1_LSB = 10 * COORD_W;
  localparam int SQ_B1_Y2_LSB = 11 * COORD_W;

  // LSB position of coordinate number idx within a snapshot
  function automatic int coord_lsb(input int idx);
    return idx * COORD_W;
  endfunction

endpackage

// File: rtl/replay_recorder_edge_detect.sv
// Registered single-cycle edge detector, rising or falling selectable.
module edge_detect #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  // Keep last cycle's level; the reset level is chosen by the parent so no false edge fires after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= rst_val_i;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign edge_o = FALLING ? (sig_q & ~sig_i) : (sig_i & ~sig_q);

endmodule

// File: rtl/replay_recorder.sv
// Capture/replay controller: records one coordinate snapshot per frame into a
// circular BRAM buffer and streams it back at one frame per vsync after game over.
module replay_recorder #(
  parameter int  ADDR_BITS  = 9,
  parameter int  COORD_W    = 12,
  parameter int  NUM_COORDS = 12,
  localparam int SNAP_W     = COORD_W * NUM_COORDS
) (
  input  logic                 CLK,
  input  logic                 RST_BTN,
  input  logic                 mode,
  input  logic                 endgame,
  input  logic                 reply,
  input  logic                 vsync,
  input  logic [SNAP_W-1:0]    snap_in,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [SNAP_W-1:0]    ram_wdata,
  input  logic [SNAP_W-1:0]    ram_rdata,
  output logic [SNAP_W-1:0]    play_data,
  output logic                 play_valid,
  output logic [1:0]           state,
  output logic [ADDR_BITS:0]   frames_stored
);

  import replay_pkg::*;

  localparam logic [ADDR_BITS-1:0] ONE_A = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   ONE_F = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  logic                 frame_tick;
  logic                 reply_rise;
  state_e               state_q;
  logic [ADDR_BITS-1:0] wr_ptr_q;
  logic [ADDR_BITS-1:0] rd_ptr_q;
  logic [ADDR_BITS:0]   frames_q;
  logic [ADDR_BITS:0]   play_left_q;
  logic                 ram_en_q;
  logic                 ram_we_q;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic [SNAP_W-1:0]    ram_wdata_q;
  logic                 rd_wait_q;
  logic [SNAP_W-1:0]    play_data_q;
  logic                 play_valid_q;

  edge_detect #(.FALLING(1'b1)) u_vsync_edge (
    .clk_i     (CLK),
    .rst_i     (RST_BTN),
    .rst_val_i (1'b1),
    .sig_i     (vsync),
    .edge_o    (frame_tick)
  );

  edge_detect #(.FALLING(1'b0)) u_reply_edge (
    .clk_i     (CLK),
    .rst_i     (RST_BTN),
    .rst_val_i (1'b0),
    .sig_i     (reply),
    .edge_o    (reply_rise)
  );

  // Control FSM with registered BRAM strobes; reads land in play_data two cycles after the strobe
  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frames_q     <= '0;
      play_left_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_wait_q    <= 1'b0;
      play_data_q  <= '0;
      play_valid_q <= 1'b0;
    end else begin
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      rd_wait_q <= ram_en_q & ~ram_we_q;
      if (rd_wait_q) begin
        play_data_q  <= ram_rdata;
        play_valid_q <= 1'b1;
      end
      if (!mode) begin
        state_q      <= IDLE;
        play_valid_q <= 1'b0;
        rd_wait_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!endgame) begin
              state_q      <= RECORD;
              wr_ptr_q     <= '0;
              frames_q     <= '0;
              play_valid_q <= 1'b0;
            end
          end
          RECORD: begin
            if (endgame) begin
              state_q <= HOLD;
            end else if (frame_tick) begin
              ram_en_q    <= 1'b1;
              ram_we_q    <= 1'b1;
              ram_addr_q  <= wr_ptr_q;
              ram_wdata_q <= snap_in;
              wr_ptr_q    <= wr_ptr_q + ONE_A;
              if (frames_q != DEPTH) begin
                frames_q <= frames_q + ONE_F;
              end
            end
          end
          HOLD: begin
            if (reply_rise && (frames_q != '0)) begin
              state_q     <= PLAY;
              rd_ptr_q    <= (frames_q == DEPTH) ? wr_ptr_q : '0;
              play_left_q <= frames_q;
            end
          end
          PLAY: begin
            if (frame_tick) begin
              ram_en_q    <= 1'b1;
              ram_addr_q  <= rd_ptr_q;
              rd_ptr_q    <= rd_ptr_q + ONE_A;
              play_left_q <= play_left_q - ONE_F;
              if (play_left_q == ONE_F) begin
                state_q <= HOLD;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign play_data     = play_data_q;
  assign play_valid    = play_valid_q;
  assign state         = state_q;
  assign frames_stored = frames_q;

endmodule
